// File: rtl/sisc_ctrl.sv
// Multicycle control unit for the SISC processor: START0/START1/FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT.
// Optional feature macro: SISC_CTRL_ILLEGAL_TRAP_EN (undefined opcodes trap to HALT and set a sticky illegal flag).
module sisc_ctrl #(
  parameter int OPC_W = 4,
  parameter int MM_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic [MM_W-1:0]  mm,
  input  logic [MM_W-1:0]  stat,
  output logic             ir_load,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             br_sel,
  output logic             pc_rst,
  output logic [1:0]       alu_op,
  output logic             sr_we,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             dm_we,
  output logic             halted,
  output logic             illegal
);

  typedef enum logic [2:0] {
    S_START0, S_START1, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [OPC_W-1:0] OP_ALU  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LOD  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_STR  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_BRA  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_BRR  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_BNR  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(15);

  state_t state_q, state_d;
  logic   op_undef, br_hit, br_taken, is_mem, trap_hit;

  assign op_undef = (opcode > OP_BNR) && (opcode != OP_HLT);
  assign is_mem   = (opcode == OP_LOD) || (opcode == OP_STR);
  // mm = 0 yields br_hit = 0: positive branches never taken, negated always taken.
  assign br_hit   = |(stat & mm);

  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      OP_BRA, OP_BRR: br_taken = br_hit;
      OP_BNE, OP_BNR: br_taken = !br_hit;
      default:        br_taken = 1'b0;
    endcase
  end

`ifdef SISC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign trap_hit = op_undef;

  always_comb begin
    illegal_d = illegal_q;
    if (state_q == S_DECODE && op_undef) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign trap_hit = 1'b0;
  assign illegal  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_START0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START0:  state_d = S_START1;
      S_START1:  state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = (opcode == OP_HLT || trap_hit) ? S_HALT : S_EXECUTE;
      S_EXECUTE: state_d = S_MEM;
      S_MEM:     state_d = S_WB;
      S_WB:      state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_START0;
    endcase
  end

  always_comb begin
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    alu_op   = 2'b10;
    sr_we    = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    dm_we    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_START0: pc_rst = 1'b1;
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        // Target is formed from the PC already incremented in FETCH.
        if (br_taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = (opcode == OP_BRR) || (opcode == OP_BNR);
        end
      end
      S_EXECUTE: begin
        if (opcode == OP_ALU) begin
          alu_op = 2'b00;
          sr_we  = 1'b1;
        end else if (opcode == OP_ADDI) begin
          alu_op = 2'b01;
          sr_we  = 1'b1;
        end else if (is_mem) begin
          alu_op = 2'b11;
        end
      end
      S_MEM: begin
        if (is_mem) alu_op = 2'b11;
        dm_we = (opcode == OP_STR);
      end
      S_WB: begin
        if (opcode == OP_ALU) begin
          alu_op = 2'b00;
          rf_we  = 1'b1;
        end else if (opcode == OP_ADDI) begin
          alu_op = 2'b01;
          rf_we  = 1'b1;
        end else if (opcode == OP_LOD) begin
          alu_op = 2'b11;
          rf_we  = 1'b1;
          wb_sel = 1'b1;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
